// File: rtl/thread_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// thread_scheduler_pkg
// Shared types and constants for the barrel-thread issue stage.
//   NUM_THREADS   : number of hardware threads (power of two, >= 2)
//   TIDX_W        : thread-index width
//   STARTUP_ADDR  : PC value the PC-vector initialiser loads for every thread
//   thread_idx_t  : thread index type
//   sched_state_e : scheduler FSM states
//   pipe_entry_t  : one delay-line slot {thread index, valid}
// -----------------------------------------------------------------------------
package thread_scheduler_pkg;

  localparam int NUM_THREADS = 16;
  localparam int TIDX_W      = $clog2(NUM_THREADS);

  localparam logic [31:0] STARTUP_ADDR = 32'h0000_0000;

  typedef logic [TIDX_W-1:0] thread_idx_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  typedef struct packed {
    thread_idx_t index;
    logic        valid;
  } pipe_entry_t;

endpackage

// File: rtl/thread_delay_line.sv
// -----------------------------------------------------------------------------
// thread_delay_line
// Fixed-depth shift register of {thread index, valid} slots. Stage 0 is the
// combinational issue slot; stages 1..DEPTH are registered.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears every stage)
//   stage0     : issue slot entering the line
//   tap        : contents of stage TAP
//   tail       : contents of the last stage
// -----------------------------------------------------------------------------
module thread_delay_line
  import thread_scheduler_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAP   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  pipe_entry_t stage0,
  output pipe_entry_t tap,
  output pipe_entry_t tail
);

  // stage_q is driven only by continuous assigns; each stage owns its own
  // register inside the generate block.
  pipe_entry_t stage_q [0:DEPTH];

  assign stage_q[0] = stage0;

  generate
    for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_stage
      pipe_entry_t slot_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          slot_reg <= '0;
        end else begin
          slot_reg <= stage_q[gi-1];
        end
      end

      assign stage_q[gi] = slot_reg;
    end
  endgenerate

  assign tap  = stage_q[TAP];
  assign tail = stage_q[DEPTH];

endmodule

// File: rtl/thread_scheduler.sv
// -----------------------------------------------------------------------------
// thread_scheduler
// Round-robin barrel-thread issue stage. A free-running index counter selects
// the thread whose PC is read each cycle; the index and its valid bit travel
// down a delay line so the PC-vector write port and execute stage see a
// matched index. Issue is held off for INIT_CYCLES after reset while the PC
// memory is initialised.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   i_thread_enable        : per-thread run mask, sampled at issue only
//   i_pc                   : PC of the thread at stage 0
//   o_thread_index_counter : issue index (PC-vector read address)
//   o_imem_addr            : registered word address i_pc[IMEM_AW+1:2]
//   o_fetch_valid          : o_imem_addr belongs to a valid issue
//   o_thread_index_execute : index at stage EXEC_STAGE (PC-vector write addr)
//   o_valid_execute        : valid bit at stage EXEC_STAGE
//   o_init_done            : high once issue is permitted
// -----------------------------------------------------------------------------
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int PIPE_DEPTH  = 8,
  parameter int EXEC_STAGE  = 4,
  parameter int INIT_CYCLES = 8,
  parameter int IMEM_AW     = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_THREADS-1:0] i_thread_enable,
  input  logic [31:0]            i_pc,
  output logic [TIDX_W-1:0]      o_thread_index_counter,
  output logic [IMEM_AW-1:0]     o_imem_addr,
  output logic                   o_fetch_valid,
  output logic [TIDX_W-1:0]      o_thread_index_execute,
  output logic                   o_valid_execute,
  output logic                   o_init_done
);

  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);

  sched_state_e         state_reg;
  thread_idx_t          counter_reg;
  logic [ICW-1:0]       init_cnt_reg;
  logic                 init_done_reg;
  logic [IMEM_AW-1:0]   imem_addr_reg;
  logic                 fetch_valid_reg;

  logic                 issue_valid;
  pipe_entry_t          issue_entry;
  pipe_entry_t          exec_entry;
  pipe_entry_t          unused_tail;
  logic                 unused_pc_bits;

  // Byte-offset and out-of-range PC bits are deliberately dropped.
  assign unused_pc_bits = ^{i_pc[31:IMEM_AW+2], i_pc[1:0]};

  // The enable mask is only consulted here, at issue; anything already in
  // the delay line keeps the valid it was issued with.
  assign issue_valid       = (state_reg == RUN) && i_thread_enable[counter_reg];
  assign issue_entry.index = counter_reg;
  assign issue_entry.valid = issue_valid;

  // Issue counter and init FSM. The counter runs in both states so the
  // barrel cadence never changes; the first valid issue therefore lands on
  // whatever thread the counter points at when RUN begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= INIT;
      counter_reg   <= '0;
      init_cnt_reg  <= '0;
      init_done_reg <= 1'b0;
    end else begin
      counter_reg <= counter_reg + TIDX_W'(1);
      case (state_reg)
        INIT: begin
          if (init_cnt_reg == INIT_LAST) begin
            state_reg     <= RUN;
            init_done_reg <= 1'b1;
          end else begin
            init_cnt_reg <= init_cnt_reg + ICW'(1);
          end
        end
        RUN: begin
          state_reg     <= RUN;
          init_done_reg <= 1'b1;
        end
        default: begin
          state_reg     <= INIT;
          init_done_reg <= 1'b0;
        end
      endcase
    end
  end

  // Fetch register, aligned with delay-line stage 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_addr_reg   <= '0;
      fetch_valid_reg <= 1'b0;
    end else begin
      imem_addr_reg   <= i_pc[IMEM_AW+1:2];
      fetch_valid_reg <= issue_valid;
    end
  end

  thread_delay_line #(
    .DEPTH (PIPE_DEPTH),
    .TAP   (EXEC_STAGE)
  ) u_delay_line (
    .clk    (clk),
    .reset  (reset),
    .stage0 (issue_entry),
    .tap    (exec_entry),
    .tail   (unused_tail)
  );

  assign o_thread_index_counter = counter_reg;
  assign o_imem_addr            = imem_addr_reg;
  assign o_fetch_valid          = fetch_valid_reg;
  assign o_thread_index_execute = exec_entry.index;
  assign o_valid_execute        = exec_entry.valid;
  assign o_init_done            = init_done_reg;

endmodule

// File: tb/tb_thread_scheduler.sv
// -----------------------------------------------------------------------------
// tb_thread_scheduler
// Self-checking bench for thread_scheduler. A reference model of the issue
// counter and init holdoff pushes expected execute/fetch results into queues
// at issue time; they are popped and compared when due.
// -----------------------------------------------------------------------------
module tb_thread_scheduler;

  localparam int EXEC = 4;

  typedef struct {
    int         due;
    logic [3:0] idx;
    logic       v;
  } exp_t;

  typedef struct {
    int         due;
    logic [9:0] addr;
    logic       v;
  } fexp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] en;
  logic [31:0] pc;
  logic [3:0]  o_thread_index_counter;
  logic [9:0]  o_imem_addr;
  logic        o_fetch_valid;
  logic [3:0]  o_thread_index_execute;
  logic        o_valid_execute;
  logic        o_init_done;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  logic [3:0] m_cnt  = 4'd0;
  int         m_init = 0;
  logic       m_run  = 1'b0;

  exp_t  exp_q[$];
  fexp_t fetch_q[$];

  thread_scheduler dut (
    .clk                    (clk),
    .reset                  (reset),
    .i_thread_enable        (en),
    .i_pc                   (pc),
    .o_thread_index_counter (o_thread_index_counter),
    .o_imem_addr            (o_imem_addr),
    .o_fetch_valid          (o_fetch_valid),
    .o_thread_index_execute (o_thread_index_execute),
    .o_valid_execute        (o_valid_execute),
    .o_init_done            (o_init_done)
  );

  always #5 clk = ~clk;

  // One clock: push expectations for the current issue, advance the model
  // across the edge, then pop and compare whatever is due.
  task automatic step();
    exp_t  e;
    fexp_t f;
    e.due  = cyc + EXEC;
    e.idx  = m_cnt;
    e.v    = m_run && en[m_cnt];
    exp_q.push_back(e);
    f.due  = cyc + 1;
    f.addr = pc[11:2];
    f.v    = e.v;
    fetch_q.push_back(f);
    @(posedge clk);
    if (reset) begin
      m_cnt  = 4'd0;
      m_init = 0;
      m_run  = 1'b0;
      foreach (exp_q[i]) begin
        exp_q[i].idx = 4'd0;
        exp_q[i].v   = 1'b0;
      end
      foreach (fetch_q[i]) begin
        fetch_q[i].addr = 10'd0;
        fetch_q[i].v    = 1'b0;
      end
    end else begin
      m_cnt = m_cnt + 4'd1;
      if (!m_run) begin
        if (m_init == 7) m_run = 1'b1;
        else m_init++;
      end
    end
    #1;
    cyc++;
    checks++;
    if (o_thread_index_counter !== m_cnt || o_init_done !== m_run)
      $display("FAIL sb_counter cyc=%0d got idx=%0d init_done=%b want idx=%0d init_done=%b",
               cyc, o_thread_index_counter, o_init_done, m_cnt, m_run);
    else passes++;
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (o_thread_index_execute !== e.idx || o_valid_execute !== e.v)
        $display("FAIL sb_execute cyc=%0d got idx=%0d v=%b want idx=%0d v=%b",
                 cyc, o_thread_index_execute, o_valid_execute, e.idx, e.v);
      else passes++;
    end
    while (fetch_q.size() > 0 && fetch_q[0].due == cyc) begin
      f = fetch_q.pop_front();
      checks++;
      if (o_imem_addr !== f.addr || o_fetch_valid !== f.v)
        $display("FAIL sb_fetch cyc=%0d got addr=%h v=%b want addr=%h v=%b",
                 cyc, o_imem_addr, o_fetch_valid, f.addr, f.v);
      else passes++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    en    = 16'hFFFF;
    pc    = 32'h0;
    repeat (3) step();
    checks++;
    if (o_thread_index_counter !== 4'd0 || o_init_done !== 1'b0 || o_fetch_valid !== 1'b0 ||
        o_valid_execute !== 1'b0 || o_thread_index_execute !== 4'd0 || o_imem_addr !== 10'd0)
      $display("FAIL reset_state got cnt=%0d done=%b fv=%b ve=%b xi=%0d addr=%h want all zero",
               o_thread_index_counter, o_init_done, o_fetch_valid, o_valid_execute,
               o_thread_index_execute, o_imem_addr);
    else passes++;
    $display("test_reset: reset state observed");
    reset = 1'b0;
    n = 0;
    while (!o_init_done && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== 8) $display("FAIL init_holdoff got %0d cycles want 8", n);
    else passes++;
    n = 0;
    while (!o_valid_execute && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== 4) $display("FAIL first_exec_latency got %0d cycles want 4", n);
    else passes++;
    $display("test_reset: holdoff and first execute latency measured");
  endtask

  task automatic test_run_sequence();
    logic [3:0] prev;
    int         wraps = 0;
    en = 16'hFFFF;
    prev = o_thread_index_counter;
    for (int i = 0; i < 40; i++) begin
      step();
      if (prev == 4'd15 && o_thread_index_counter == 4'd0) wraps++;
      prev = o_thread_index_counter;
    end
    checks++;
    if (wraps < 2) $display("FAIL counter_wrap got %0d wraps want >=2", wraps);
    else passes++;
    $display("test_run_sequence: 40 cycles, %0d wraps", wraps);
  endtask

  task automatic test_sparse_mask();
    int cnt0 = 0, cnt2 = 0, other = 0, first0 = -1, last0 = -1;
    en = 16'h0005;
    repeat (EXEC) step();
    for (int i = 0; i < 48; i++) begin
      step();
      if (o_valid_execute) begin
        if (o_thread_index_execute == 4'd0) begin
          cnt0++;
          if (first0 < 0) first0 = cyc;
          last0 = cyc;
        end else if (o_thread_index_execute == 4'd2) cnt2++;
        else other++;
      end
    end
    checks++;
    if (other !== 0 || cnt0 !== 3 || cnt2 !== 3)
      $display("FAIL sparse_counts got t0=%0d t2=%0d other=%0d want 3 3 0", cnt0, cnt2, other);
    else passes++;
    checks++;
    if (last0 - first0 !== 32) $display("FAIL sparse_period got %0d want 32", last0 - first0);
    else passes++;
    $display("test_sparse_mask: t0=%0d t2=%0d other=%0d", cnt0, cnt2, other);
  endtask

  task automatic test_mask_flip();
    int n = 0;
    en = 16'hFFFF;
    repeat (EXEC) step();
    while (o_thread_index_counter != 4'd9 && n < 32) begin
      step();
      n++;
    end
    checks++;
    if (o_thread_index_counter !== 4'd9) $display("FAIL flip_sync got %0d want 9", o_thread_index_counter);
    else passes++;
    en = 16'h0000;
    repeat (2) step();
    checks++;
    if (o_thread_index_execute !== 4'd7 || o_valid_execute !== 1'b1)
      $display("FAIL flip_inflight7 got idx=%0d v=%b want idx=7 v=1", o_thread_index_execute, o_valid_execute);
    else passes++;
    step();
    checks++;
    if (o_thread_index_execute !== 4'd8 || o_valid_execute !== 1'b1)
      $display("FAIL flip_inflight8 got idx=%0d v=%b want idx=8 v=1", o_thread_index_execute, o_valid_execute);
    else passes++;
    step();
    checks++;
    if (o_thread_index_execute !== 4'd9 || o_valid_execute !== 1'b0)
      $display("FAIL flip_after got idx=%0d v=%b want idx=9 v=0", o_thread_index_execute, o_valid_execute);
    else passes++;
    $display("test_mask_flip: thread 7 and 8 executed, thread 9 suppressed");
  endtask

  task automatic test_fetch();
    en = 16'hFFFF;
    repeat (EXEC) step();
    pc = 32'h0000_0ABC;
    step();
    checks++;
    if (o_imem_addr !== 10'h2AF || o_fetch_valid !== 1'b1)
      $display("FAIL fetch_addr got addr=%h v=%b want addr=2af v=1", o_imem_addr, o_fetch_valid);
    else passes++;
    en = 16'h0000;
    pc = 32'hDEAD_BFF7;
    step();
    checks++;
    if (o_imem_addr !== 10'h3FD || o_fetch_valid !== 1'b0)
      $display("FAIL fetch_trunc got addr=%h v=%b want addr=3fd v=0", o_imem_addr, o_fetch_valid);
    else passes++;
    $display("test_fetch: address truncation observed");
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    en = 16'hFFFF;
    pc = 32'h0000_1234;
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (o_fetch_valid !== 1'b0 || o_valid_execute !== 1'b0 || o_init_done !== 1'b0 ||
        o_thread_index_counter !== 4'd0)
      $display("FAIL midrun_reset got fv=%b ve=%b done=%b cnt=%0d want 0 0 0 0",
               o_fetch_valid, o_valid_execute, o_init_done, o_thread_index_counter);
    else passes++;
    while (!o_init_done && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== 8) $display("FAIL midrun_holdoff got %0d cycles want 8", n);
    else passes++;
    repeat (EXEC + 2) step();
    $display("test_reset_midrun: holdoff repeated after %0d cycles", n);
  endtask

  initial begin
    reset = 1'b1;
    en    = 16'hFFFF;
    pc    = 32'h0;
    test_reset();
    test_run_sequence();
    test_sparse_mask();
    test_mask_flip();
    test_fetch();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
